// File: rtl/dope_pkg.sv
// Shared op codes and sequencer state encoding for the DOPE frame-pass path.
package dope_pkg;

  localparam logic [2:0] OP_WRITE  = 3'b000;
  localparam logic [2:0] OP_INVERT = 3'b001;
  localparam logic [2:0] OP_BW     = 3'b010;
  localparam logic [2:0] OP_OFFSET = 3'b011;
  localparam logic [2:0] OP_NOP    = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  // Any op with the top bit set is treated as a no-op pass.
  function automatic logic is_nop(input logic [2:0] code);
    return code[2];
  endfunction

endpackage

// File: rtl/dope_addr_counter.sv
// Clear/enable address counter that saturates at LAST and flags the terminal count.
module dope_addr_counter #(
  parameter int ADDR_W = 15,
  parameter logic [ADDR_W-1:0] LAST = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              at_last
);

  assign at_last = (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_last) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dope_sequencer.sv
// Frame-pass controller feeding the DOPE pixel unit; walks all frame-buffer addresses per pass.
// Optional abort input/aborted pulse enabled by defining DOPE_SEQ_ABORT_EN.
module dope_sequencer
  import dope_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op_in,
  input  logic [2:0]        offset_in,
  input  logic [7:0]        fill_pixel_in,
`ifdef DOPE_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic [2:0]        op,
  output logic [2:0]        offset,
  output logic [7:0]        write_pixel,
  output logic              buffer_select,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              write_en
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  seq_state_t state;
  logic       real_pass;
  logic       at_last;
  logic       cnt_clear;
  logic       cnt_enable;
  logic       abort_hit;

  assign cnt_clear  = (state == IDLE) && start && !is_nop(op_in);
  assign cnt_enable = (state == RUN);

`ifdef DOPE_SEQ_ABORT_EN
  assign abort_hit = abort && ((state == RUN) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  dope_addr_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (LAST)
  ) u_rd_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .count   (rd_addr),
    .at_last (at_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      real_pass     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      op            <= OP_NOP;
      offset        <= 3'd0;
      write_pixel   <= 8'd0;
      buffer_select <= 1'b0;
      wr_addr       <= '0;
      write_en      <= 1'b0;
`ifdef DOPE_SEQ_ABORT_EN
      aborted       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DOPE_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      if (abort_hit) begin
        state    <= IDLE;
        busy     <= 1'b0;
        write_en <= 1'b0;
`ifdef DOPE_SEQ_ABORT_EN
        aborted  <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (!is_nop(op_in)) begin
                op          <= op_in;
                offset      <= offset_in;
                write_pixel <= fill_pixel_in;
                real_pass   <= 1'b1;
                state       <= RUN;
              end else begin
                real_pass <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end
            end
          end
          RUN: begin
            // Write trails the read by one cycle to cover the RAM read latency.
            write_en <= 1'b1;
            wr_addr  <= rd_addr;
            if (at_last) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            write_en <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
          DONE: begin
            busy <= 1'b0;
            if (real_pass) begin
              buffer_select <= ~buffer_select;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
